// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok interface. Drives a synchronous
// single-port RAM and returns in-order responses with configurable delays and optional random stalls.
module sram_like_responder #(
  parameter int          ADDR_WAIT = 0,
  parameter int          DATA_WAIT = 1,
  parameter int          RAND_EN   = 0,
  parameter logic [15:0] LFSR_SEED = 16'h5a5a
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int WW = (ADDR_WAIT > 0) ? $clog2(ADDR_WAIT + 1) : 1;
  localparam int AW = $clog2(DATA_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(ADDR_WAIT);
  localparam logic [AW-1:0] AMAX = AW'(DATA_WAIT);

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [31:0]   data;
    logic          dvalid;
    logic [AW-1:0] age;
  } entry_t;

  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [WW-1:0] wcnt;
  logic [1:0]    cnt;
  entry_t        q [2];
  entry_t        head;
  logic          hd;
  logic          tl;
  logic          cap_pend;
  logic          cap_idx;
  logic          rand_a;
  logic          rand_d;
  logic          handshake;
  logic          unused_bits;

  assign unused_bits = ^{size, addr[1:0]};

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rand_a  = (RAND_EN == 0) || lfsr[0];
  assign rand_d  = (RAND_EN == 0) || lfsr[1];

  // wcnt saturates at ADDR_WAIT, so equality is the same as "at least ADDR_WAIT"
  assign addr_ok   = !reset && req && (wcnt == WMAX) && (cnt != 2'd2) && rand_a;
  assign handshake = req && addr_ok;

  assign ram_en    = handshake;
  assign ram_wen   = (handshake && wr) ? wstrb : 4'h0;
  assign ram_addr  = {addr[31:2], 2'b00};
  assign ram_wdata = wdata;

  assign head    = q[hd];
  assign data_ok = !reset && head.valid && (head.age == AMAX) && rand_d;

  // Head not yet captured means it was pushed last cycle, so the RAM output is its data
  always_comb begin
    rdata = 32'h0;
    if (data_ok && !head.wr)
      rdata = head.dvalid ? head.data : ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= LFSR_SEED;
      wcnt     <= '0;
      cnt      <= 2'd0;
      hd       <= 1'b0;
      tl       <= 1'b0;
      cap_pend <= 1'b0;
      cap_idx  <= 1'b0;
      for (int i = 0; i < 2; i++) q[i] <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};

      if (!req || handshake)
        wcnt <= '0;
      else if (wcnt != WMAX)
        wcnt <= wcnt + WW'(1);

      for (int i = 0; i < 2; i++) begin
        if (q[i].valid && (q[i].age != AMAX))
          q[i].age <= q[i].age + AW'(1);
      end

      if (cap_pend) begin
        q[cap_idx].data   <= ram_rdata;
        q[cap_idx].dvalid <= 1'b1;
      end

      if (data_ok) begin
        q[hd].valid <= 1'b0;
        hd          <= ~hd;
      end

      // A new entry has already spent its handshake cycle at age 0
      if (handshake) begin
        q[tl].valid  <= 1'b1;
        q[tl].wr     <= wr;
        q[tl].data   <= 32'h0;
        q[tl].dvalid <= wr;
        q[tl].age    <= AW'(1);
        tl           <= ~tl;
      end

      cap_pend <= handshake && !wr;
      cap_idx  <= tl;

      case ({handshake, data_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed and scoreboarded bench for sram_like_responder across four parameter sets:
// defaults, DATA_WAIT=3, ADDR_WAIT=2, and RAND_EN=1.
module tb_sram_like_responder;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0]       req, wr, addr_ok, data_ok, ram_en;
  logic [NI-1:0][1:0]  size;
  logic [NI-1:0][3:0]  wstrb, ram_wen;
  logic [NI-1:0][31:0] addr, wdata, rdata, ram_addr, ram_wdata, ram_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] mem [256];
    logic [31:0] rd_q;

    sram_like_responder #(
      .ADDR_WAIT(g == 2 ? 2 : (g == 3 ? 1 : 0)),
      .DATA_WAIT(g == 1 ? 3 : (g == 3 ? 2 : 1)),
      .RAND_EN  (g == 3 ? 1 : 0),
      .LFSR_SEED(16'h5a5a)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req[g]),
      .wr       (wr[g]),
      .size     (size[g]),
      .addr     (addr[g]),
      .wstrb    (wstrb[g]),
      .wdata    (wdata[g]),
      .addr_ok  (addr_ok[g]),
      .data_ok  (data_ok[g]),
      .rdata    (rdata[g]),
      .ram_en   (ram_en[g]),
      .ram_wen  (ram_wen[g]),
      .ram_addr (ram_addr[g]),
      .ram_wdata(ram_wdata[g]),
      .ram_rdata(ram_rdata[g])
    );

    // read-first synchronous RAM, 1-cycle latency
    always @(posedge clk) begin
      if (ram_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[g][b]) mem[ram_addr[g][9:2]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
        rd_q <= mem[ram_addr[g][9:2]];
      end
    end
    assign ram_rdata[g] = rd_q;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int g, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    req[g]   = 1'b1;
    wr[g]    = w;
    addr[g]  = a;
    wstrb[g] = s;
    wdata[g] = d;
    size[g]  = 2'd2;
  endtask

  task automatic xfer(input int g, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] exp, input string tag);
    int k;
    set_req(g, w, a, s, d);
    settle();
    k = 0;
    while (!addr_ok[g] && k < 20) begin next_cycle(); settle(); k++; end
    check({tag, "_hs"}, 32'(addr_ok[g]), 32'd1);
    next_cycle();
    req[g] = 1'b0;
    settle();
    k = 0;
    while (!data_ok[g] && k < 20) begin next_cycle(); settle(); k++; end
    check({tag, "_dok"}, 32'(data_ok[g]), 32'd1);
    check(tag, rdata[g], exp);
    next_cycle();
  endtask

  initial begin : main
    logic [31:0] model [16];
    logic [31:0] expq [$];
    logic [3:0]  ridx;
    int n_hs, n_dok, n_issued, cyc;
    logic pend;

    req = '0; wr = '0; size = '0; addr = '0; wstrb = '0; wdata = '0;
    reset = 1'b1;
    next_cycle();
    req[0] = 1'b1;
    settle();
    check("rst_addr_ok", 32'(addr_ok[0]), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_data_ok", 32'(data_ok), 32'd0);
    next_cycle();
    reset = 1'b0;
    req[0] = 1'b0;
    settle();
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_ram_wen", 32'(ram_wen[0]), 32'h0);

    // preload, then single read with low address bits dropped
    set_req(0, 1'b1, 32'hbfc00000, 4'hf, 32'h3c1d0001);
    settle();
    check("w0_addr_ok", 32'(addr_ok[0]), 32'd1);
    check("w0_ram_wen", 32'(ram_wen[0]), 32'hf);
    check("w0_ram_wdata", ram_wdata[0], 32'h3c1d0001);
    next_cycle();
    req[0] = 1'b0;
    settle();
    check("w0_data_ok", 32'(data_ok[0]), 32'd1);
    check("w0_rdata", rdata[0], 32'h0);
    check("w0_idle_ram_en", 32'(ram_en[0]), 32'd0);
    next_cycle();
    set_req(0, 1'b0, 32'hbfc00002, 4'hf, 32'hdeadbeef);
    settle();
    check("r0_addr_ok", 32'(addr_ok[0]), 32'd1);
    check("r0_ram_en", 32'(ram_en[0]), 32'd1);
    check("r0_ram_wen", 32'(ram_wen[0]), 32'h0);
    check("r0_ram_addr", ram_addr[0], 32'hbfc00000);
    next_cycle();
    req[0] = 1'b0;
    settle();
    check("r0_data_ok", 32'(data_ok[0]), 32'd1);
    check("r0_rdata", rdata[0], 32'h3c1d0001);
    next_cycle();
    settle();
    check("r0_one_dok", 32'(data_ok[0]), 32'd0);

    // byte strobes
    xfer(0, 1'b1, 32'h100, 4'hf, 32'h11223344, 32'h0, "w100");
    xfer(0, 1'b1, 32'h100, 4'h3, 32'haabbccdd, 32'h0, "wstrb03");
    xfer(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h1122ccdd, "rd_merge03");
    xfer(0, 1'b1, 32'h100, 4'h4, 32'h00ee0000, 32'h0, "wstrb04");
    xfer(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h11eeccdd, "rd_merge04");

    // back-to-back reads with defaults
    set_req(0, 1'b0, 32'hbfc00000, 4'h0, 32'h0);
    settle();
    check("b2b_hs0", 32'(addr_ok[0]), 32'd1);
    next_cycle();
    addr[0] = 32'h100;
    settle();
    check("b2b_hs1", 32'(addr_ok[0]), 32'd1);
    check("b2b_dok0", 32'(data_ok[0]), 32'd1);
    check("b2b_rd0", rdata[0], 32'h3c1d0001);
    next_cycle();
    req[0] = 1'b0;
    settle();
    check("b2b_dok1", 32'(data_ok[0]), 32'd1);
    check("b2b_rd1", rdata[0], 32'h11eeccdd);
    next_cycle();

    // DATA_WAIT=3, queue-full stall
    xfer(1, 1'b1, 32'h4, 4'hf, 32'ha1a1a1a1, 32'h0, "u1_wa");
    xfer(1, 1'b1, 32'h8, 4'hf, 32'hb2b2b2b2, 32'h0, "u1_wb");
    xfer(1, 1'b1, 32'hc, 4'hf, 32'hc3c3c3c3, 32'h0, "u1_wc");
    set_req(1, 1'b0, 32'h4, 4'h0, 32'h0);
    settle();
    check("dw3_hsA", 32'(addr_ok[1]), 32'd1);
    next_cycle();
    addr[1] = 32'h8;
    settle();
    check("dw3_hsB", 32'(addr_ok[1]), 32'd1);
    check("dw3_dok_t1", 32'(data_ok[1]), 32'd0);
    next_cycle();
    addr[1] = 32'hc;
    settle();
    check("dw3_full_t2", 32'(addr_ok[1]), 32'd0);
    check("dw3_dok_t2", 32'(data_ok[1]), 32'd0);
    next_cycle();
    settle();
    check("dw3_full_t3", 32'(addr_ok[1]), 32'd0);
    check("dw3_dokA", 32'(data_ok[1]), 32'd1);
    check("dw3_rdA", rdata[1], 32'ha1a1a1a1);
    next_cycle();
    settle();
    check("dw3_hsC", 32'(addr_ok[1]), 32'd1);
    check("dw3_dokB", 32'(data_ok[1]), 32'd1);
    check("dw3_rdB", rdata[1], 32'hb2b2b2b2);
    next_cycle();
    req[1] = 1'b0;
    settle();
    check("dw3_dok_t5", 32'(data_ok[1]), 32'd0);
    next_cycle();
    settle();
    check("dw3_dok_t6", 32'(data_ok[1]), 32'd0);
    next_cycle();
    settle();
    check("dw3_dokC", 32'(data_ok[1]), 32'd1);
    check("dw3_rdC", rdata[1], 32'hc3c3c3c3);
    next_cycle();

    // reset with two outstanding reads
    set_req(1, 1'b0, 32'h4, 4'h0, 32'h0);
    settle();
    check("mrst_hs0", 32'(addr_ok[1]), 32'd1);
    next_cycle();
    addr[1] = 32'h8;
    settle();
    check("mrst_hs1", 32'(addr_ok[1]), 32'd1);
    next_cycle();
    req[1] = 1'b0;
    reset = 1'b1;
    settle();
    check("mrst_dok_in_rst", 32'(data_ok[1]), 32'd0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("mrst_quiet", 32'(data_ok[1]), 32'd0);
      next_cycle();
    end
    set_req(1, 1'b0, 32'hc, 4'h0, 32'h0);
    settle();
    check("mrst_after_hs0", 32'(addr_ok[1]), 32'd1);
    next_cycle();
    addr[1] = 32'h4;
    settle();
    check("mrst_after_hs1", 32'(addr_ok[1]), 32'd1);
    next_cycle();
    req[1] = 1'b0;
    settle();
    check("mrst_after_dok_t2", 32'(data_ok[1]), 32'd0);
    next_cycle();
    settle();
    check("mrst_after_dok0", 32'(data_ok[1]), 32'd1);
    check("mrst_after_rd0", rdata[1], 32'hc3c3c3c3);
    next_cycle();
    settle();
    check("mrst_after_dok1", 32'(data_ok[1]), 32'd1);
    check("mrst_after_rd1", rdata[1], 32'ha1a1a1a1);
    next_cycle();

    // ADDR_WAIT=2
    set_req(2, 1'b1, 32'h0, 4'hf, 32'h12345678);
    settle();
    check("aw_c0", 32'(addr_ok[2]), 32'd0);
    next_cycle();
    req[2] = 1'b0;
    settle();
    check("aw_c1_low", 32'(addr_ok[2]), 32'd0);
    next_cycle();
    req[2] = 1'b1;
    settle();
    check("aw_c2", 32'(addr_ok[2]), 32'd0);
    next_cycle();
    settle();
    check("aw_c3", 32'(addr_ok[2]), 32'd0);
    next_cycle();
    settle();
    check("aw_c4", 32'(addr_ok[2]), 32'd1);
    check("aw_c4_wen", 32'(ram_wen[2]), 32'hf);
    next_cycle();
    settle();
    check("aw_c5", 32'(addr_ok[2]), 32'd0);
    check("aw_c5_dok", 32'(data_ok[2]), 32'd1);
    check("aw_c5_rdata", rdata[2], 32'h0);
    next_cycle();
    settle();
    check("aw_c6", 32'(addr_ok[2]), 32'd0);
    next_cycle();
    settle();
    check("aw_c7", 32'(addr_ok[2]), 32'd1);
    next_cycle();
    req[2] = 1'b0;
    settle();
    check("aw_c8_dok", 32'(data_ok[2]), 32'd1);
    next_cycle();

    // RAND_EN=1: 16 preload writes then 1000 random ops against a word model
    n_hs = 0; n_dok = 0; n_issued = 0; cyc = 0; pend = 1'b0;
    while ((n_issued < 1016 || pend || expq.size() != 0) && cyc < 20000) begin
      if (!pend && n_issued < 1016 && (n_issued < 16 || $urandom_range(0, 3) != 0)) begin
        if (n_issued < 16)
          set_req(3, 1'b1, {26'h0, 4'(n_issued), 2'b00}, 4'hf, $urandom);
        else
          set_req(3, 1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                  4'($urandom_range(0, 15)), $urandom);
        pend = 1'b1;
        n_issued++;
      end
      settle();
      if (data_ok[3]) begin
        n_dok++;
        if (expq.size() == 0) check("rnd_spurious_dok", 32'(data_ok[3]), 32'd0);
        else check("rnd_rdata", rdata[3], expq.pop_front());
      end
      if (req[3] && addr_ok[3]) begin
        n_hs++;
        ridx = addr[3][5:2];
        if (wr[3]) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[3][b]) model[ridx][8*b +: 8] = wdata[3][8*b +: 8];
          expq.push_back(32'h0);
        end else begin
          expq.push_back(model[ridx]);
        end
        pend = 1'b0;
      end
      next_cycle();
      if (!pend) req[3] = 1'b0;
      cyc++;
    end
    check("rnd_handshakes", 32'(n_hs), 32'd1016);
    check("rnd_dok_count", 32'(n_dok), 32'(n_hs));
    check("rnd_drained", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
